// File: rtl/keypad_scan.sv
// Matrix-keypad scanner: strobes active-low columns, debounces a full-matrix snapshot
// and hands one key code per press to the consumer over valid/ready.
module keypad_scan #(
    parameter int unsigned ROWS     = 4,
    parameter int unsigned COLS     = 4,
    parameter int unsigned SCAN_DIV = 50000,
    parameter int unsigned DEBOUNCE = 4
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic [ROWS-1:0]                   row_in,
    output logic [COLS-1:0]                   col_out,
    output logic [$clog2(ROWS*COLS)-1:0]      key_code,
    output logic                              key_valid,
    input  logic                              key_ready,
    output logic                              key_pressed,
    output logic                              overflow
);

    localparam int unsigned RW = $clog2(ROWS);
    localparam int unsigned CW = $clog2(COLS);
    localparam int unsigned KW = $clog2(ROWS*COLS);
    localparam int unsigned DW = $clog2(SCAN_DIV);
    localparam int unsigned NW = $clog2(DEBOUNCE+1);

    typedef enum logic {EMPTY, FULL} state_t;

    logic [ROWS-1:0] row_s1, row_s2;
    logic [DW-1:0]   div;
    logic [CW-1:0]   col_idx, col_nxt;
    logic            slot_end, scan_end;

    logic            col_hit;
    logic [RW-1:0]   col_row;
    logic            snap_hit, scan_hit;
    logic [KW-1:0]   snap_code, scan_code;

    logic            cand_hit;
    logic [KW-1:0]   cand_code, stable_code;
    logic [NW-1:0]   cnt, cnt_nxt;
    logic            same;

    logic            ev;
    logic [KW-1:0]   ev_code;

    state_t          state, state_nxt;
    logic [KW-1:0]   code_nxt;
    logic            valid_nxt, ovf_nxt;

    assign slot_end = (div == DW'(SCAN_DIV-1));
    assign scan_end = slot_end && (col_idx == CW'(COLS-1));
    assign col_nxt  = slot_end ? ((col_idx == CW'(COLS-1)) ? '0 : col_idx + CW'(1)) : col_idx;

    // Lowest closed row in the column currently strobed
    always_comb begin
        col_hit = 1'b0;
        col_row = '0;
        for (int unsigned r = 0; r < ROWS; r++) begin
            if (!row_s2[r] && !col_hit) begin
                col_hit = 1'b1;
                col_row = RW'(r);
            end
        end
    end

    // Snapshot of the scan including the slot being sampled now; earlier columns win
    always_comb begin
        scan_hit  = snap_hit || col_hit;
        scan_code = snap_hit ? snap_code : {col_row, col_idx};
        same      = (scan_hit == cand_hit) && (!scan_hit || (scan_code == cand_code));
        if (!same)
            cnt_nxt = NW'(1);
        else if (cnt == NW'(DEBOUNCE))
            cnt_nxt = cnt;
        else
            cnt_nxt = cnt + NW'(1);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            row_s1      <= '1;
            row_s2      <= '1;
            div         <= '0;
            col_idx     <= '0;
            col_out     <= ~COLS'(1);
            snap_hit    <= 1'b0;
            snap_code   <= '0;
            cand_hit    <= 1'b0;
            cand_code   <= '0;
            cnt         <= '0;
            key_pressed <= 1'b0;
            stable_code <= '0;
            ev          <= 1'b0;
            ev_code     <= '0;
        end else begin
            row_s1  <= row_in;
            row_s2  <= row_s1;
            div     <= slot_end ? '0 : div + DW'(1);
            col_idx <= col_nxt;
            col_out <= ~(COLS'(1) << col_nxt);
            ev      <= 1'b0;
            if (scan_end) begin
                snap_hit  <= 1'b0;
                snap_code <= '0;
                cand_hit  <= scan_hit;
                cand_code <= scan_code;
                cnt       <= cnt_nxt;
                if (cnt_nxt == NW'(DEBOUNCE)) begin
                    key_pressed <= scan_hit;
                    stable_code <= scan_code;
                    ev          <= scan_hit && (!key_pressed || (stable_code != scan_code));
                    ev_code     <= scan_code;
                end
            end else if (slot_end) begin
                snap_hit  <= scan_hit;
                snap_code <= scan_code;
            end
        end
    end

    // Output handshake: one-entry holding register
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= EMPTY;
            key_code  <= '0;
            key_valid <= 1'b0;
            overflow  <= 1'b0;
        end else begin
            state     <= state_nxt;
            key_code  <= code_nxt;
            key_valid <= valid_nxt;
            overflow  <= ovf_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        code_nxt  = key_code;
        valid_nxt = key_valid;
        ovf_nxt   = 1'b0;
        case (state)
            EMPTY: begin
                if (ev) begin
                    code_nxt  = ev_code;
                    valid_nxt = 1'b1;
                    state_nxt = FULL;
                end
            end
            FULL: begin
                if (key_ready) begin
                    if (ev) begin
                        code_nxt = ev_code;
                    end else begin
                        valid_nxt = 1'b0;
                        state_nxt = EMPTY;
                    end
                end else if (ev) begin
                    ovf_nxt = 1'b1;
                end
            end
            default: state_nxt = EMPTY;
        endcase
    end

endmodule

// File: tb/tb_keypad_scan.sv
// Bench for keypad_scan: a key-matrix model drives row_in from col_out; a scan-level
// reference model predicts debounced state and handshake outputs.
module tb_keypad_scan;

    localparam int ROWS = 4;
    localparam int COLS = 4;
    localparam int SD   = 4;
    localparam int DB   = 2;

    logic        clk = 1'b0;
    logic        rst;
    logic [3:0]  row_in;
    logic [3:0]  col_out;
    logic [3:0]  key_code;
    logic        key_valid;
    logic        key_ready;
    logic        key_pressed;
    logic        overflow;
    logic [15:0] mask;

    int vectors = 0;
    int miscompares = 0;
    int ovf_seen = 0;

    int m_cand, m_cnt, m_stable, m_ev_key, m_code;
    bit m_valid;

    keypad_scan #(.ROWS(ROWS), .COLS(COLS), .SCAN_DIV(SD), .DEBOUNCE(DB)) dut (
        .clk(clk), .rst(rst), .row_in(row_in), .col_out(col_out),
        .key_code(key_code), .key_valid(key_valid), .key_ready(key_ready),
        .key_pressed(key_pressed), .overflow(overflow)
    );

    always #5 clk = ~clk;

    // Physical matrix: a closed key pulls its row low while its column is strobed
    always_comb begin
        row_in = '1;
        for (int r = 0; r < ROWS; r++)
            for (int c = 0; c < COLS; c++)
                if (!col_out[c] && mask[r*COLS+c]) row_in[r] = 1'b0;
    end

    always @(negedge clk) if (overflow === 1'b1) ovf_seen++;

    function automatic int first_key(input logic [15:0] m);
        for (int c = 0; c < COLS; c++)
            for (int r = 0; r < ROWS; r++)
                if (m[r*COLS+c]) return r*COLS + c;
        return -1;
    endfunction

    function automatic logic [15:0] key_bit(input int k);
        logic [15:0] b;
        b = 16'd1;
        return b << k;
    endfunction

    task automatic model_reset();
        m_cand = -1; m_cnt = 0; m_stable = -1; m_ev_key = -1;
        m_valid = 1'b0; m_code = 0;
    endtask

    task automatic do_reset();
        @(posedge clk); #1;
        rst = 1'b1;
        key_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        model_reset();
    endtask

    // One full scan with a fixed key set and ready level; checks the cycle after the
    // previous end-of-scan edge and right after this scan's end-of-scan edge.
    task automatic run_scan(input logic [15:0] m, input logic r, input string tag);
        int  snap;
        bit  exp_ovf;
        mask = m;
        key_ready = r;
        @(posedge clk); #1;
        exp_ovf = 1'b0;
        if (!m_valid) begin
            if (m_ev_key >= 0) begin m_valid = 1'b1; m_code = m_ev_key; end
        end else if (r) begin
            if (m_ev_key >= 0) m_code = m_ev_key;
            else m_valid = 1'b0;
        end else if (m_ev_key >= 0) begin
            exp_ovf = 1'b1;
        end
        m_ev_key = -1;
        vectors++;
        if (key_valid !== m_valid || key_code !== 4'(m_code) || overflow !== exp_ovf ||
            key_pressed !== (m_stable >= 0)) begin
            miscompares++;
            $display("FAIL %s start: got valid=%b code=%0d ovf=%b pressed=%b expected valid=%b code=%0d ovf=%b pressed=%b",
                     tag, key_valid, key_code, overflow, key_pressed, m_valid, m_code, exp_ovf, m_stable >= 0);
        end
        if (m_valid && r) m_valid = 1'b0;
        repeat (SD*COLS-1) @(posedge clk);
        #1;
        snap = first_key(m);
        if (snap == m_cand) begin
            if (m_cnt < DB) m_cnt++;
        end else begin
            m_cand = snap;
            m_cnt = 1;
        end
        if (m_cnt == DB) begin
            if (m_cand >= 0 && m_cand != m_stable) m_ev_key = m_cand;
            m_stable = m_cand;
        end
        vectors++;
        if (key_valid !== m_valid || key_code !== 4'(m_code) || overflow !== 1'b0 ||
            key_pressed !== (m_stable >= 0) || col_out !== 4'b1110) begin
            miscompares++;
            $display("FAIL %s end: got valid=%b code=%0d ovf=%b pressed=%b col=%b expected valid=%b code=%0d ovf=0 pressed=%b col=1110",
                     tag, key_valid, key_code, overflow, key_pressed, col_out, m_valid, m_code, m_stable >= 0);
        end
    endtask

    task automatic test_reset();
        mask = '0;
        do_reset();
        vectors++;
        if (col_out !== 4'b1110 || key_valid !== 1'b0 || key_code !== 4'd0 ||
            key_pressed !== 1'b0 || overflow !== 1'b0) begin
            miscompares++;
            $display("FAIL reset: got col=%b valid=%b code=%0d pressed=%b ovf=%b expected col=1110 valid=0 code=0 pressed=0 ovf=0",
                     col_out, key_valid, key_code, key_pressed, overflow);
        end
    endtask

    task automatic test_col_walk();
        logic [3:0] one;
        logic [3:0] exp;
        one = 4'b0001;
        mask = '0;
        do_reset();
        for (int k = 1; k <= 16; k++) begin
            @(posedge clk); #1;
            exp = ~(one << ((k / SD) % COLS));
            vectors++;
            if (col_out !== exp) begin
                miscompares++;
                $display("FAIL col_walk cycle %0d: got %b expected %b", k, col_out, exp);
            end
        end
    endtask

    task automatic test_single_press();
        do_reset();
        for (int i = 0; i < 3; i++) run_scan(key_bit(9), 1'b0, "press9");
        vectors++;
        if (key_valid !== 1'b1 || key_code !== 4'd9 || key_pressed !== 1'b1) begin
            miscompares++;
            $display("FAIL press9 delivered: got valid=%b code=%0d pressed=%b expected valid=1 code=9 pressed=1",
                     key_valid, key_code, key_pressed);
        end
        run_scan(key_bit(9), 1'b1, "press9_pop");
        run_scan(key_bit(9), 1'b0, "press9_hold");
    endtask

    task automatic test_glitch();
        do_reset();
        run_scan(key_bit(9), 1'b0, "glitch_on");
        for (int i = 0; i < 3; i++) run_scan('0, 1'b0, "glitch_off");
        vectors++;
        if (key_valid !== 1'b0 || key_pressed !== 1'b0) begin
            miscompares++;
            $display("FAIL glitch: got valid=%b pressed=%b expected valid=0 pressed=0", key_valid, key_pressed);
        end
    endtask

    task automatic test_overflow();
        int ovf0;
        do_reset();
        for (int i = 0; i < 3; i++) run_scan(key_bit(9), 1'b0, "ovf_9");
        ovf0 = ovf_seen;
        for (int i = 0; i < 3; i++) run_scan(key_bit(4), 1'b0, "ovf_4");
        vectors++;
        if (key_code !== 4'd9 || ovf_seen - ovf0 != 1) begin
            miscompares++;
            $display("FAIL overflow: got code=%0d pulses=%0d expected code=9 pulses=1", key_code, ovf_seen - ovf0);
        end
        run_scan(key_bit(4), 1'b1, "ovf_pop");
        for (int i = 0; i < 2; i++) run_scan(key_bit(4), 1'b0, "ovf_nostale");
        vectors++;
        if (key_valid !== 1'b0) begin
            miscompares++;
            $display("FAIL overflow stale: got valid=%b expected 0", key_valid);
        end
    endtask

    task automatic test_back_to_back();
        do_reset();
        for (int i = 0; i < 3; i++) run_scan(key_bit(9), 1'b0, "b2b_9");
        for (int i = 0; i < 2; i++) run_scan(key_bit(4), 1'b0, "b2b_4");
        run_scan(key_bit(4), 1'b1, "b2b_take");
        run_scan(key_bit(4), 1'b0, "b2b_after");
    endtask

    task automatic test_multi_key();
        do_reset();
        for (int i = 0; i < 3; i++) run_scan(key_bit(4) | key_bit(9), 1'b0, "multi");
        vectors++;
        if (key_code !== 4'd4) begin
            miscompares++;
            $display("FAIL multi code: got %0d expected 4", key_code);
        end
        for (int i = 0; i < 3; i++) run_scan('0, 1'b1, "release");
        vectors++;
        if (key_valid !== 1'b0 || key_pressed !== 1'b0) begin
            miscompares++;
            $display("FAIL release: got valid=%b pressed=%b expected valid=0 pressed=0", key_valid, key_pressed);
        end
    endtask

    task automatic test_reset_mid();
        do_reset();
        for (int i = 0; i < 3; i++) run_scan(key_bit(9), 1'b0, "mid_pre");
        repeat (5) @(posedge clk);
        do_reset();
        vectors++;
        if (col_out !== 4'b1110 || key_valid !== 1'b0 || key_code !== 4'd0 ||
            key_pressed !== 1'b0 || overflow !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_mid: got col=%b valid=%b code=%0d pressed=%b ovf=%b expected col=1110 valid=0 code=0 pressed=0 ovf=0",
                     col_out, key_valid, key_code, key_pressed, overflow);
        end
        for (int i = 0; i < 3; i++) run_scan(key_bit(9), 1'b0, "mid_post");
        vectors++;
        if (key_valid !== 1'b1 || key_code !== 4'd9) begin
            miscompares++;
            $display("FAIL reset_mid rereport: got valid=%b code=%0d expected valid=1 code=9", key_valid, key_code);
        end
    endtask

    task automatic test_random();
        logic [15:0] m;
        int sel;
        m = '0;
        do_reset();
        for (int i = 0; i < 48; i++) begin
            sel = int'($urandom_range(0, 9));
            if (sel < 2)      m = '0;
            else if (sel < 4) m = key_bit(int'($urandom_range(0, 15)));
            else if (sel < 5) m = key_bit(int'($urandom_range(0, 15))) | key_bit(int'($urandom_range(0, 15)));
            run_scan(m, ($urandom_range(0, 3) == 0), "random");
        end
    endtask

    initial begin
        rst = 1'b1;
        key_ready = 1'b0;
        mask = '0;
        model_reset();
        test_reset();
        test_col_walk();
        test_single_press();
        test_glitch();
        test_overflow();
        test_back_to_back();
        test_multi_key();
        test_reset_mid();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
